// File: rtl/pkt_capture.sv
// Captures whole MAC receive packets into the packet FIFO and hands each one to wr_ctrl
// with its length, timestamp and ring-buffer destination address.
module pkt_capture #(
   parameter int unsigned MAX_PKT_BYTES = 1518,
   parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
   parameter logic [31:0] BUF_SIZE      = 32'h0010_0000,
   parameter int unsigned SLOT_MAX      = 1536
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_data,
   input  logic        st_sop,
   input  logic        st_eop,
   input  logic [1:0]  st_empty,
   input  logic [31:0] seconds,
   input  logic [31:0] nanoseconds,
   output logic        fifo_wrreq,
   output logic [31:0] fifo_data,
   input  logic        fifo_full,
   output logic        wr_ctrl,
   input  logic        wr_ctrl_rdy,
   output logic [31:0] control,
   output logic [31:0] pkt_begin,
   output logic [31:0] pkt_end,
   output logic [31:0] write_address,
   output logic [31:0] pkt_seconds,
   output logic [31:0] pkt_nanoseconds,
   output logic [31:0] pkt_count,
   output logic [31:0] drop_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_DRAIN,
      S_ISSUE,
      S_WAIT_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] byte_cnt_q, byte_cnt_d;
   logic        trunc_q, trunc_d;
   logic        miss_eop_q, miss_eop_d;
   logic        fifo_wrreq_q, fifo_wrreq_d;
   logic [31:0] fifo_data_q, fifo_data_d;
   logic        wr_ctrl_q, wr_ctrl_d;
   logic [31:0] control_q, control_d;
   logic [31:0] pkt_end_q, pkt_end_d;
   logic [31:0] write_address_q, write_address_d;
   logic [31:0] pkt_seconds_q, pkt_seconds_d;
   logic [31:0] pkt_nanoseconds_q, pkt_nanoseconds_d;
   logic [31:0] pkt_count_q, pkt_count_d;
   logic [31:0] drop_count_q, drop_count_d;

   logic [31:0] beat_bytes;
   logic [31:0] byte_sum;
   logic [31:0] len_rnd4;
   logic [31:0] rec_adv;
   logic [31:0] addr_inc;
   logic [31:0] addr_next;

   // Record = 16-byte header + word-padded payload, rounded up to a 64-byte slot.
   always_comb begin
      beat_bytes = st_eop ? (32'd4 - {30'd0, st_empty}) : 32'd4;
      byte_sum   = byte_cnt_q + beat_bytes;
      len_rnd4   = (pkt_end_q + 32'd3) & ~32'd3;
      rec_adv    = (len_rnd4 + 32'd16 + 32'd63) & ~32'd63;
      addr_inc   = write_address_q + rec_adv;
      addr_next  = (addr_inc + SLOT_MAX > BUF_BASE + BUF_SIZE) ? BUF_BASE : addr_inc;
   end

   // NOTE: every _d gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d           = state_q;
      byte_cnt_d        = byte_cnt_q;
      trunc_d           = trunc_q;
      miss_eop_d        = miss_eop_q;
      fifo_wrreq_d      = 1'b0;
      fifo_data_d       = fifo_data_q;
      wr_ctrl_d         = 1'b0;
      control_d         = control_q;
      pkt_end_d         = pkt_end_q;
      write_address_d   = write_address_q;
      pkt_seconds_d     = pkt_seconds_q;
      pkt_nanoseconds_d = pkt_nanoseconds_q;
      pkt_count_d       = pkt_count_q;
      drop_count_d      = drop_count_q;

      unique case (state_q)
         S_IDLE: begin
            if (st_valid && st_sop && enable) begin
               pkt_seconds_d     = seconds;
               pkt_nanoseconds_d = nanoseconds;
               miss_eop_d        = 1'b0;
               if (fifo_full) begin
                  trunc_d    = 1'b1;
                  byte_cnt_d = 32'd0;
                  state_d    = st_eop ? S_ISSUE : S_DRAIN;
               end else begin
                  trunc_d      = 1'b0;
                  fifo_wrreq_d = 1'b1;
                  fifo_data_d  = st_data;
                  byte_cnt_d   = beat_bytes;
                  state_d      = st_eop ? S_ISSUE : S_RECV;
               end
            end
         end

         S_RECV: begin
            if (st_valid) begin
               if (st_sop) begin
                  miss_eop_d   = 1'b1;
                  drop_count_d = drop_count_q + 32'd1;
                  state_d      = S_ISSUE;
               end else if (fifo_full) begin
                  trunc_d = 1'b1;
                  state_d = st_eop ? S_ISSUE : S_DRAIN;
               end else if (byte_sum > MAX_PKT_BYTES) begin
                  // The crossing beat still carries the last stored bytes.
                  trunc_d      = 1'b1;
                  fifo_wrreq_d = 1'b1;
                  fifo_data_d  = st_data;
                  byte_cnt_d   = MAX_PKT_BYTES;
                  state_d      = st_eop ? S_ISSUE : S_DRAIN;
               end else begin
                  fifo_wrreq_d = 1'b1;
                  fifo_data_d  = st_data;
                  byte_cnt_d   = byte_sum;
                  if (st_eop) state_d = S_ISSUE;
               end
            end
         end

         S_DRAIN: begin
            if (st_valid) begin
               if (st_sop) begin
                  miss_eop_d   = 1'b1;
                  drop_count_d = drop_count_q + 32'd1;
                  state_d      = S_ISSUE;
               end else if (st_eop) begin
                  state_d = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            wr_ctrl_d   = 1'b1;
            pkt_end_d   = byte_cnt_q;
            control_d   = {30'd0, miss_eop_q, trunc_q};
            pkt_count_d = pkt_count_q + 32'd1;
            if (st_valid && st_sop && enable) drop_count_d = drop_count_q + 32'd1;
            state_d     = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            if (st_valid && st_sop && enable) drop_count_d = drop_count_q + 32'd1;
            if (wr_ctrl_rdy) begin
               write_address_d = addr_next;
               state_d         = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= S_IDLE;
         byte_cnt_q        <= '0;
         trunc_q           <= 1'b0;
         miss_eop_q        <= 1'b0;
         fifo_wrreq_q      <= 1'b0;
         fifo_data_q       <= '0;
         wr_ctrl_q         <= 1'b0;
         control_q         <= '0;
         pkt_end_q         <= '0;
         write_address_q   <= BUF_BASE;
         pkt_seconds_q     <= '0;
         pkt_nanoseconds_q <= '0;
         pkt_count_q       <= '0;
         drop_count_q      <= '0;
      end else begin
         state_q           <= state_d;
         byte_cnt_q        <= byte_cnt_d;
         trunc_q           <= trunc_d;
         miss_eop_q        <= miss_eop_d;
         fifo_wrreq_q      <= fifo_wrreq_d;
         fifo_data_q       <= fifo_data_d;
         wr_ctrl_q         <= wr_ctrl_d;
         control_q         <= control_d;
         pkt_end_q         <= pkt_end_d;
         write_address_q   <= write_address_d;
         pkt_seconds_q     <= pkt_seconds_d;
         pkt_nanoseconds_q <= pkt_nanoseconds_d;
         pkt_count_q       <= pkt_count_d;
         drop_count_q      <= drop_count_d;
      end
   end

   assign st_ready        = 1'b1;
   assign fifo_wrreq      = fifo_wrreq_q;
   assign fifo_data       = fifo_data_q;
   assign wr_ctrl         = wr_ctrl_q;
   assign control         = control_q;
   assign pkt_begin       = 32'd0;
   assign pkt_end         = pkt_end_q;
   assign write_address   = write_address_q;
   assign pkt_seconds     = pkt_seconds_q;
   assign pkt_nanoseconds = pkt_nanoseconds_q;
   assign pkt_count       = pkt_count_q;
   assign drop_count      = drop_count_q;

endmodule

// File: doc/pkt_capture.md
Name: pkt_capture

Overview:
- Upstream neighbour of wr_ctrl in the capture datapath.
- Accepts the MAC receive stream (Avalon-ST, 32-bit, no backpressure to the MAC).
- Stores whole packets into the shared 512x32 packet FIFO and latches a timestamp at start-of-packet.
- At end-of-packet, issues one wr_ctrl request with the packet length and a ring-buffer destination address, then waits for wr_ctrl_rdy before capturing the next packet.

Parameters:
- MAX_PKT_BYTES, 1518: longest stored packet; bytes beyond this are truncated.
- BUF_BASE, 32'h0000_0000: first byte address of the host capture ring.
- BUF_SIZE, 32'h0010_0000: ring size in bytes; must be a multiple of 64.
- SLOT_MAX, 1536: worst-case record size, roundup64(16+MAX_PKT_BYTES).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  capture enable, sampled only at SOP
- st_valid  in  1  stream beat valid
- st_ready  out  1  constant 1 (MAC cannot be stalled)
- st_data  in  32  stream data
- st_sop  in  1  start of packet
- st_eop  in  1  end of packet
- st_empty  in  2  unused bytes in the EOP beat
- seconds  in  32  free-running time, seconds
- nanoseconds  in  32  free-running time, nanoseconds
- fifo_wrreq  out  1  FIFO write strobe
- fifo_data  out  32  FIFO write data
- fifo_full  in  1  FIFO full
- wr_ctrl  out  1  one-cycle request to wr_ctrl
- wr_ctrl_rdy  in  1  one-cycle completion from wr_ctrl
- control  out  32  [0] truncated, [1] missing-EOP error, others 0
- pkt_begin  out  32  always 0
- pkt_end  out  32  stored packet length in bytes
- write_address  out  32  record destination address
- pkt_seconds  out  32  seconds latched at SOP
- pkt_nanoseconds  out  32  nanoseconds latched at SOP
- pkt_count  out  32  captured packets
- drop_count  out  32  dropped packets

Behaviour:
- Reset values: all outputs 0, except st_ready=1 and write_address=BUF_BASE. State goes to IDLE. The FIFO shares this reset, so a reset mid-packet discards the partial packet with no request issued.
- A beat is accepted when st_valid=1 (st_ready is always 1).
- State machine: IDLE, RECV, DRAIN, ISSUE, WAIT_DONE.
- IDLE:
  - A beat with st_sop=1 and enable=1 latches pkt_seconds/pkt_nanoseconds, writes the beat, clears the byte counter and flags, and goes to RECV. If st_eop=1 on the same beat, go directly to ISSUE.
  - A beat with st_sop=1 and enable=0 is ignored and not counted.
  - A non-SOP beat is ignored.
- RECV:
  - Each beat is written to the FIFO and adds 4 bytes to the counter, or 4-st_empty on the EOP beat.
  - EOP goes to ISSUE.
  - If the next beat's bytes would exceed MAX_PKT_BYTES, set control[0], stop FIFO writes, clamp the count to MAX_PKT_BYTES, and go to DRAIN.
  - fifo_full on an accepted beat is handled the same way as truncation (control[0]).
  - A beat with st_sop=1 in RECV: close the current packet at its present count with control[1]=1, go to ISSUE, and drop the new packet (drop_count+1).
- DRAIN: consume beats without writing until EOP, then go to ISSUE. An SOP arriving in DRAIN gets the same handling as in RECV.
- FIFO write timing:
  - fifo_wrreq and fifo_data are registered, asserted the cycle after the beat is accepted.
  - Words are written unmodified; the EOP word keeps its unused bytes.
- ISSUE (one cycle):
  - wr_ctrl=1.
  - pkt_end = byte count; pkt_begin=0.
  - pkt_count+1, wrapping modulo 2^32.
  - This state is entered 2 cycles after the EOP beat is accepted, i.e. 1 cycle after the last FIFO write.
- WAIT_DONE:
  - control, pkt_end, pkt_begin, write_address and pkt_* stay stable until wr_ctrl_rdy.
  - Every SOP beat seen here with enable=1 is dropped: drop_count+1, no FIFO write.
  - On wr_ctrl_rdy, advance the ring pointer and go to IDLE.
  - If wr_ctrl_rdy and an SOP beat arrive in the same cycle, that SOP is dropped.
- Ring pointer arithmetic:
  - adv = roundup64(16 + roundup4(pkt_end)).
  - next = write_address + adv.
  - If next + SLOT_MAX > BUF_BASE + BUF_SIZE, then next = BUF_BASE.
  - All arithmetic is 32-bit unsigned.
- Counters wrap modulo 2^32; no saturation.

Test Plan:
- 64-byte packet at write_address=0 (16 beats, st_empty=0, seconds=5, nanoseconds=100 at SOP) -> 16 fifo_wrreq pulses; wr_ctrl 2 cycles after EOP with pkt_end=64, control=0, pkt_seconds=5, pkt_nanoseconds=100; after wr_ctrl_rdy, write_address=128.
- 61-byte packet (EOP beat st_empty=3) -> 16 FIFO words, pkt_end=61; pointer advances by roundup64(16+64)=128.
- 2000-byte packet -> exactly 379 FIFO words plus a partial, following the defined clamp (count=1518); control[0]=1, pkt_end=1518; request issued only after EOP.
- Second packet whose SOP arrives while in WAIT_DONE -> no FIFO writes, drop_count=1. A third packet arriving after wr_ctrl_rdy is captured normally, pkt_count=2.
- BUF_SIZE=4096, write_address=2432, packet pkt_end=64 -> next = 2560, and 2560+1536 = 4096 is not > 4096, so write_address=2560. The next 64-byte packet gives 2688+1536 > 4096, so write_address wraps to 0.
- SOP mid-RECV after 10 beats -> request with pkt_end=40, control[1]=1, drop_count+1. Separately, reset asserted mid-RECV -> outputs return to reset values and no wr_ctrl is issued.
